mult_seq_16b: RTL and testbench

MULT_SEQ_16B -- requirements
Module: mult_seq_16b

---
 rtl/mult_seq_16b.sv | 141 ++++++++++++++
 tb/tb_mult_seq_16b.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_16b.sv
// Sequential 16x16 unsigned shift-add multiplier built around a single cla_16b adder.
// Also holds cla_16b, a two-level 4-bit-group carry-lookahead adder.

module cla_16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cIn,
    output logic [15:0] sum,
    output logic        cOut
);
    logic [15:0] g, p, c;
    logic [3:0]  gg, gp, gc, cin_grp;

    function automatic logic [2:0] look3(input logic [2:0] gi, input logic [2:0] pi,
                                         input logic ci);
        logic [2:0] co;
        co[0] = gi[0] | (pi[0] & ci);
        co[1] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
        co[2] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (&pi & ci);
        return co;
    endfunction

    function automatic logic [3:0] look4(input logic [3:0] gi, input logic [3:0] pi,
                                         input logic ci);
        logic c4;
        c4 = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
           | (pi[3] & pi[2] & pi[1] & gi[0]) | (&pi & ci);
        return {c4, look3(gi[2:0], pi[2:0], ci)};
    endfunction

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        gg = '0;
        gp = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (&p[4*k+3 -: 2] & g[4*k+1])
                  | (&p[4*k+3 -: 3] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
    end

    // Second lookahead level resolves every group carry-in directly from cIn.
    assign gc      = look4(gg, gp, cIn);
    assign cin_grp = {gc[2:0], cIn};

    always_comb begin
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k]       = cin_grp[k];
            c[4*k+1 +: 3] = look3(g[4*k +: 3], p[4*k +: 3], cin_grp[k]);
        end
    end

    assign sum  = p ^ c;
    assign cOut = gc[3];
endmodule

module mult_seq_16b #(
    parameter int unsigned N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   in1,
    input  logic [N-1:0]   in2,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e       state_q, state_d;
    logic [N-1:0] mcand_q, mcand_d;
    logic [N-1:0] acc_hi_q, acc_hi_d;
    logic [N-1:0] acc_lo_q, acc_lo_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [N-1:0] addend, sum;
    logic         cout;

    assign addend = acc_lo_q[0] ? mcand_q : '0;

    cla_16b u_cla (
        .a    (acc_hi_q),
        .b    (addend),
        .cIn  (1'b0),
        .sum  (sum),
        .cOut (cout)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d  = in1;
                    acc_hi_d = '0;
                    acc_lo_d = in2;
                    cnt_d    = '0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                // Carry-out becomes the new MSB so the full 32-bit product survives.
                acc_hi_d = {cout, sum[N-1:1]};
                acc_lo_d = {sum[0], acc_lo_q[N-1:1]};
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign product = {acc_hi_q, acc_lo_q};
endmodule

// File: tb/tb_mult_seq_16b.sv
// Directed and random checks for mult_seq_16b: values, 17-cycle latency, 18-cycle period,
// start filtering and reset behaviour.

module tb_mult_seq_16b;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] in1, in2;
    logic        busy, done;
    logic [31:0] product;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    mult_seq_16b #(.N(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in1     (in1),
        .in2     (in2),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Call at a negedge with the DUT idle; returns at the negedge of the idle cycle after done.
    task automatic do_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, output int done_cyc);
        int k;
        int busy_cnt;
        int done_at;
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in1   = 16'($urandom);
        in2   = 16'($urandom);
        k        = 1;
        busy_cnt = 0;
        done_at  = 0;
        done_cyc = 0;
        while (k <= 40 && done_at == 0) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_at  = k;
                done_cyc = cyc;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        chk($sformatf("%s.latency", nm), done_at, 17);
        chk($sformatf("%s.busy_cycles", nm), busy_cnt, 17);
        chk($sformatf("%s.product", nm), product, exp);
        @(negedge clk);
        chk($sformatf("%s.idle_after", nm), {30'd0, busy, done}, 32'd0);
        chk($sformatf("%s.product_held", nm), product, exp);
    endtask

    initial begin
        int          dc;
        int          prev_dc;
        int          dones;
        int          done_k;
        logic [15:0] ra, rb;

        vecs[0]  = '{16'd3,    16'd5,    32'h0000000F};
        vecs[1]  = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2]  = '{16'h8000, 16'h0002, 32'h00010000};
        vecs[3]  = '{16'h1234, 16'h0000, 32'h00000000};
        vecs[4]  = '{16'h0000, 16'hABCD, 32'h00000000};
        vecs[5]  = '{16'd6,    16'd7,    32'h0000002A};
        vecs[6]  = '{16'h00FF, 16'h0101, 32'h0000FFFF};
        vecs[7]  = '{16'h1000, 16'h1000, 32'h01000000};
        vecs[8]  = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
        vecs[9]  = '{16'h0100, 16'h00FF, 32'h0000FF00};
        vecs[10] = '{16'h1234, 16'h0010, 32'h00012340};
        vecs[11] = '{16'h0001, 16'h8000, 32'h00008000};

        rst   = 1'b1;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        repeat (3) @(negedge clk);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk("reset.product", product, 32'd0);

        // rst wins over a simultaneous start.
        start = 1'b1;
        in1   = 16'd3;
        in2   = 16'd5;
        @(negedge clk);
        chk("rst_prio.busy", {31'd0, busy}, 32'd0);
        chk("rst_prio.product", product, 32'd0);
        rst = 1'b0;

        // First vector starts in the first cycle after rst deasserts.
        for (int i = 0; i < 12; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, dc);
        end

        // Starts during BUSY cycle 5 and during DONE must be ignored.
        in1   = 16'd7;
        in2   = 16'd9;
        start = 1'b1;
        @(negedge clk);
        dones  = 0;
        done_k = 0;
        for (int k = 1; k <= 24; k++) begin
            if (done) begin
                dones++;
                done_k = k;
            end
            if (k == 5 || k == 17) begin
                start = 1'b1;
                in1   = 16'd2 + 16'(k);
                in2   = 16'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("ignore.done_count", dones, 1);
        chk("ignore.done_cycle", done_k, 17);
        chk("ignore.product", product, 32'h0000003F);
        chk("ignore.busy", {31'd0, busy}, 32'd0);

        // Reset in BUSY cycle 8 aborts the operation.
        in1   = 16'd5;
        in2   = 16'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 8; k++) @(negedge clk);
        chk("abort.busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.done", {31'd0, done}, 32'd0);
        chk("abort.product", product, 32'd0);
        do_op("after_abort", 16'd6, 16'd7, 32'h0000002A, dc);

        // Back-to-back random operands; period between done pulses must be 18 cycles.
        prev_dc = 0;
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            do_op($sformatf("rnd%0d", i), ra, rb, {16'd0, ra} * {16'd0, rb}, dc);
            if (i != 0) chk($sformatf("rnd%0d.period", i), dc - prev_dc, 18);
            prev_dc = dc;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
